// File: rtl/uart_calc_pkg.sv
// Shared constants, op_code encodings and FSM states for the UART calculator sequencer.
package uart_calc_pkg;

    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_ESC   = 8'h1B;
    localparam logic [7:0] ASC_QM    = 8'h3F;
    localparam logic [7:0] ASC_PLUS  = 8'h2B;
    localparam logic [7:0] ASC_MINUS = 8'h2D;
    localparam logic [7:0] ASC_STAR  = 8'h2A;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10
    } op_code_t;

    typedef enum logic [2:0] {
        S_OPA,
        S_OPB,
        S_EXEC,
        S_WAIT,
        S_SEND,
        S_ERR
    } state_t;

    function automatic logic is_op_char(input logic [7:0] c);
        return (c == ASC_PLUS) || (c == ASC_MINUS) || (c == ASC_STAR);
    endfunction

    function automatic op_code_t op_of(input logic [7:0] c);
        case (c)
            ASC_MINUS: return OP_SUB;
            ASC_STAR:  return OP_MUL;
            default:   return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/uart_calc_ctrl_if.sv
// ALU launch/complete handshake between the sequencer (master) and the ALU (slave).
interface uart_calc_ctrl_if #(
    parameter int unsigned W  = 16,
    parameter int unsigned RW = 2 * W
);
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [1:0]    op_code;
    logic          alu_start;
    logic          alu_done;
    logic [RW-1:0] alu_result;

    modport master (
        output op_a, op_b, op_code, alu_start,
        input  alu_done, alu_result
    );

    modport slave (
        input  op_a, op_b, op_code, alu_start,
        output alu_done, alu_result
    );
endinterface

// File: rtl/uart_calc_ctrl_hex_ascii.sv
// Combinational hex <-> ASCII converter; ENCODE selects nibble->ASCII, otherwise ASCII->nibble.
module hex_ascii #(
    parameter bit ENCODE = 1'b0
) (
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       valid
);
    generate
        if (ENCODE) begin : g_enc
            // Upper nibble must be zero for the input to be a single hex digit.
            always_comb begin
                valid = (din[7:4] == 4'h0);
                if (din[3:0] < 4'hA) dout = 8'h30 + {4'h0, din[3:0]};
                else                 dout = 8'h37 + {4'h0, din[3:0]};
            end
        end else begin : g_dec
            always_comb begin
                valid = 1'b1;
                dout  = '0;
                if (din >= 8'h30 && din <= 8'h39)      dout = din - 8'h30;
                else if (din >= 8'h41 && din <= 8'h46) dout = din - 8'h37;
                else if (din >= 8'h61 && din <= 8'h66) dout = din - 8'h57;
                else                                   valid = 1'b0;
            end
        end
    endgenerate
endmodule

// File: rtl/uart_calc_ctrl.sv
// Frame parser / ALU launcher / hex result printer between UART RX, ALU and UART TX.
// Optional RX echo to TX is enabled by defining UART_CALC_ECHO_EN.
module uart_calc_ctrl
    import uart_calc_pkg::*;
#(
    parameter int unsigned W  = 16,
    parameter int unsigned RW = 2 * W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          rx_data,
    input  logic                rx_val,
    uart_calc_ctrl_if.master    alu,
    output logic [7:0]          tx_data,
    output logic                tx_start,
    input  logic                tx_busy,
    output logic                rx_drop
);
    localparam int unsigned CW = $clog2(W / 4 + 1);
    localparam int unsigned IW = $clog2(RW / 4 + 2);
    localparam logic [CW-1:0] NDIG   = CW'(W / 4);
    localparam logic [IW-1:0] IDX_CR = IW'(RW / 4);
    localparam logic [IW-1:0] IDX_LF = IW'(RW / 4 + 1);

    state_t        state, state_n;
    logic [W-1:0]  a_q, a_n, b_q, b_n;
    logic [CW-1:0] cnt, cnt_n;
    op_code_t      opc_q, opc_n;
    logic [RW-1:0] res_q, res_n;
    logic [IW-1:0] idx, idx_n;
    logic          start_q, start_n;
    logic          tx_start_q, tx_start_n;
    logic [7:0]    tx_data_q, tx_data_n;
    logic          drop_q, drop_n;
    logic          tx_ok, echo_pend;

    logic [7:0] dec_byte, enc_byte;
    logic       dig_valid, enc_valid;

`ifdef UART_CALC_ECHO_EN
    logic       echo_full, echo_full_n;
    logic [7:0] echo_byte, echo_byte_n;
`endif

    hex_ascii #(.ENCODE(1'b0)) u_dec (
        .din   (rx_data),
        .dout  (dec_byte),
        .valid (dig_valid)
    );

    hex_ascii #(.ENCODE(1'b1)) u_enc (
        .din   ({4'h0, res_q[RW-1 -: 4]}),
        .dout  (enc_byte),
        .valid (enc_valid)
    );

    assign alu.op_a      = a_q;
    assign alu.op_b      = b_q;
    assign alu.op_code   = opc_q;
    assign alu.alu_start = start_q;
    assign tx_data       = tx_data_q;
    assign tx_start      = tx_start_q;
    assign rx_drop       = drop_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_OPA;
            a_q        <= '0;
            b_q        <= '0;
            cnt        <= '0;
            opc_q      <= OP_ADD;
            res_q      <= '0;
            idx        <= '0;
            start_q    <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            drop_q     <= 1'b0;
`ifdef UART_CALC_ECHO_EN
            echo_full  <= 1'b0;
            echo_byte  <= '0;
`endif
        end else begin
            state      <= state_n;
            a_q        <= a_n;
            b_q        <= b_n;
            cnt        <= cnt_n;
            opc_q      <= opc_n;
            res_q      <= res_n;
            idx        <= idx_n;
            start_q    <= start_n;
            tx_start_q <= tx_start_n;
            tx_data_q  <= tx_data_n;
            drop_q     <= drop_n;
`ifdef UART_CALC_ECHO_EN
            echo_full  <= echo_full_n;
            echo_byte  <= echo_byte_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        a_n        = a_q;
        b_n        = b_q;
        cnt_n      = cnt;
        opc_n      = opc_q;
        res_n      = res_q;
        idx_n      = idx;
        start_n    = 1'b0;
        tx_start_n = 1'b0;
        tx_data_n  = tx_data_q;
        tx_ok      = !tx_busy && !tx_start_q;
        echo_pend  = 1'b0;
        drop_n     = rx_val && (state != S_OPA) && (state != S_OPB);

`ifdef UART_CALC_ECHO_EN
        // A pending echo always owns the next TX slot; a buffer drained this cycle may be refilled.
        echo_full_n = echo_full;
        echo_byte_n = echo_byte;
        echo_pend   = echo_full;
        if (tx_ok && echo_full) begin
            tx_start_n  = 1'b1;
            tx_data_n   = echo_byte;
            echo_full_n = 1'b0;
        end
        if (rx_val && (state == S_OPA || state == S_OPB) && !echo_full_n) begin
            echo_full_n = 1'b1;
            echo_byte_n = rx_data;
        end
`endif

        unique case (state)
            S_OPA, S_OPB: begin
                if (rx_val) begin
                    if (rx_data == ASC_ESC) begin
                        a_n     = '0;
                        b_n     = '0;
                        cnt_n   = '0;
                        state_n = S_OPA;
                    end else if (rx_data == ASC_LF) begin
                        state_n = state;
                    end else if (dig_valid && cnt != NDIG) begin
                        cnt_n = cnt + CW'(1);
                        if (state == S_OPA) a_n = (a_q << 4) | W'(dec_byte);
                        else                b_n = (b_q << 4) | W'(dec_byte);
                    end else if (state == S_OPA && is_op_char(rx_data) && cnt != '0) begin
                        opc_n   = op_of(rx_data);
                        cnt_n   = '0;
                        state_n = S_OPB;
                    end else if (state == S_OPB && rx_data == ASC_CR && cnt != '0) begin
                        state_n = S_EXEC;
                    end else begin
                        idx_n   = '0;
                        state_n = S_ERR;
                    end
                end
            end
            S_EXEC: begin
                start_n = 1'b1;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (alu.alu_done) begin
                    res_n   = alu.alu_result;
                    idx_n   = '0;
                    state_n = S_SEND;
                end
            end
            S_SEND: begin
                if (tx_ok && !echo_pend) begin
                    tx_start_n = 1'b1;
                    idx_n      = idx + IW'(1);
                    if (idx < IDX_CR) begin
                        tx_data_n = enc_valid ? enc_byte : ASC_QM;
                        res_n     = res_q << 4;
                    end else if (idx == IDX_CR) begin
                        tx_data_n = ASC_CR;
                    end else begin
                        tx_data_n = ASC_LF;
                        a_n       = '0;
                        b_n       = '0;
                        cnt_n     = '0;
                        idx_n     = '0;
                        state_n   = S_OPA;
                    end
                end
            end
            S_ERR: begin
                if (tx_ok && !echo_pend) begin
                    tx_start_n = 1'b1;
                    idx_n      = idx + IW'(1);
                    if (idx == '0) begin
                        tx_data_n = ASC_QM;
                    end else if (idx == IW'(1)) begin
                        tx_data_n = ASC_CR;
                    end else begin
                        tx_data_n = ASC_LF;
                        a_n       = '0;
                        b_n       = '0;
                        cnt_n     = '0;
                        idx_n     = '0;
                        state_n   = S_OPA;
                    end
                end
            end
            default: state_n = S_OPA;
        endcase
    end
endmodule

// File: tb/tb_uart_calc_ctrl.sv
// Directed self-checking bench for uart_calc_ctrl (W=16); echo scenario runs when UART_CALC_ECHO_EN is defined.
module tb_uart_calc_ctrl;
    import uart_calc_pkg::*;

    localparam int unsigned W  = 16;
    localparam int unsigned RW = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_val = 1'b0;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy = 1'b0;
    logic       rx_drop;

    int n_checks = 0;
    int n_fail   = 0;
    int busy_cnt = 0;
    int alu_cnt  = 0;
    int drop_cnt = 0;
    logic [7:0] txq[$];

    uart_calc_ctrl_if #(.W(W), .RW(RW)) alu_if ();

    uart_calc_ctrl #(.W(W), .RW(RW)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_val   (rx_val),
        .alu      (alu_if.master),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .rx_drop  (rx_drop)
    );

    always #5 clk = ~clk;

    // Transmitter stand-in: captures each byte, stays busy for a few cycles.
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (busy_cnt != 0) busy_cnt--;
            if (tx_start) begin
                txq.push_back(tx_data);
                busy_cnt = 3;
            end
            if (alu_if.alu_start) alu_cnt++;
            if (rx_drop) drop_cnt++;
        end
        tx_busy = (busy_cnt != 0);
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk); #1;
        rx_data = b;
        rx_val  = 1'b1;
        @(negedge clk); #1;
        rx_val  = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], gap);
    endtask

    task automatic wait_alu(input string name);
        int t = 0;
        while (alu_cnt == 0 && t < 100) begin
            @(negedge clk); #2;
            t++;
        end
        n_checks++;
        if (alu_cnt == 0) begin
            n_fail++;
            $display("FAIL %s: alu_start count %0d, required at least 1", name, alu_cnt);
        end
    endtask

    task automatic alu_reply(input logic [RW-1:0] r);
        @(negedge clk); #1;
        alu_if.alu_done   = 1'b1;
        alu_if.alu_result = r;
        @(negedge clk); #1;
        alu_if.alu_done   = 1'b0;
    endtask

    task automatic expect_tx(input string name, input string exp);
        int    t = 0;
        bit    ok;
        string got_s = "";
        string exp_s = "";
        while (txq.size() < exp.len() && t < 500) begin
            @(negedge clk); #2;
            t++;
        end
        repeat (12) @(negedge clk);
        #2;
        ok = (txq.size() == exp.len());
        for (int i = 0; i < exp.len(); i++)
            if (i < txq.size() && txq[i] !== exp[i]) ok = 1'b0;
        foreach (txq[i]) got_s = $sformatf("%s%02h ", got_s, txq[i]);
        for (int i = 0; i < exp.len(); i++) exp_s = $sformatf("%s%02h ", exp_s, exp[i]);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: tx bytes [%s] required [%s]", name, got_s, exp_s);
        end
        txq.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({alu_if.op_a, alu_if.op_b, alu_if.op_code, alu_if.alu_start, tx_start, tx_data, rx_drop} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: a=%h b=%h opc=%b start=%b txs=%b txd=%h drop=%b, required all 0",
                     alu_if.op_a, alu_if.op_b, alu_if.op_code, alu_if.alu_start, tx_start, tx_data, rx_drop);
        end
        n_checks++;
        if (dut.state !== S_OPA || dut.cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d cnt=%0d, required state=%0d cnt=0", dut.state, dut.cnt, S_OPA);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_add();
        alu_cnt = 0;
        send_str("1F+2A\015", 1);
        wait_alu("add_start");
        n_checks++;
        if (alu_if.op_a !== 16'h001F) begin n_fail++; $display("FAIL add_op_a: got %h required 001f", alu_if.op_a); end
        n_checks++;
        if (alu_if.op_b !== 16'h002A) begin n_fail++; $display("FAIL add_op_b: got %h required 002a", alu_if.op_b); end
        n_checks++;
        if (alu_if.op_code !== 2'b00) begin n_fail++; $display("FAIL add_op_code: got %b required 00", alu_if.op_code); end
        alu_reply(32'h0000_0049);
        expect_tx("add_tx", "00000049\015\012");
        n_checks++;
        if (alu_cnt != 1) begin n_fail++; $display("FAIL add_start_count: got %0d required 1", alu_cnt); end
    endtask

    task automatic test_sub_lower();
        alu_cnt = 0;
        send_str("ff-1\015", 1);
        wait_alu("sub_start");
        n_checks++;
        if (alu_if.op_a !== 16'h00FF) begin n_fail++; $display("FAIL sub_op_a: got %h required 00ff", alu_if.op_a); end
        n_checks++;
        if (alu_if.op_b !== 16'h0001) begin n_fail++; $display("FAIL sub_op_b: got %h required 0001", alu_if.op_b); end
        n_checks++;
        if (alu_if.op_code !== 2'b01) begin n_fail++; $display("FAIL sub_op_code: got %b required 01", alu_if.op_code); end
        alu_reply(32'hFFFF_FFFF);
        expect_tx("sub_tx", "FFFFFFFF\015\012");
    endtask

    task automatic test_overflow();
        alu_cnt = 0;
        send_str("12345+1\015", 1);
        expect_tx("overflow_tx", "?\015\012");
        n_checks++;
        if (alu_cnt != 0) begin n_fail++; $display("FAIL overflow_no_start: got %0d required 0", alu_cnt); end
        send_str("2*3\015", 1);
        wait_alu("mul_start");
        n_checks++;
        if (alu_if.op_code !== 2'b10) begin n_fail++; $display("FAIL mul_op_code: got %b required 10", alu_if.op_code); end
        n_checks++;
        if ({alu_if.op_a, alu_if.op_b} !== {16'h0002, 16'h0003}) begin
            n_fail++;
            $display("FAIL mul_ops: got a=%h b=%h required a=0002 b=0003", alu_if.op_a, alu_if.op_b);
        end
        alu_reply(32'h0000_0006);
        expect_tx("mul_tx", "00000006\015\012");
    endtask

    task automatic test_missing_operand();
        alu_cnt  = 0;
        drop_cnt = 0;
        send_str("+5\015", 1);
        expect_tx("no_opa_tx", "?\015\012");
        n_checks++;
        if (drop_cnt != 2) begin n_fail++; $display("FAIL no_opa_drops: got %0d required 2", drop_cnt); end
        send_str("5+\015", 1);
        expect_tx("no_opb_tx", "?\015\012");
        n_checks++;
        if (alu_cnt != 0) begin n_fail++; $display("FAIL missing_no_start: got %0d required 0", alu_cnt); end
    endtask

    task automatic test_drop_in_wait();
        alu_cnt = 0;
        send_str("4*5\015", 1);
        wait_alu("wait_start");
        drop_cnt = 0;
        send_str("9+9", 1);
        repeat (3) @(negedge clk);
        n_checks++;
        if (drop_cnt != 3) begin n_fail++; $display("FAIL wait_drops: got %0d required 3", drop_cnt); end
        n_checks++;
        if ({alu_if.op_a, alu_if.op_b} !== {16'h0004, 16'h0005}) begin
            n_fail++;
            $display("FAIL wait_ops_held: got a=%h b=%h required a=0004 b=0005", alu_if.op_a, alu_if.op_b);
        end
        alu_reply(32'h0000_0014);
        expect_tx("wait_tx", "00000014\015\012");
    endtask

    task automatic test_esc_and_reset();
        int t = 0;
        alu_cnt = 0;
        send_str("7\0333*3\015", 1);
        wait_alu("esc_start");
        n_checks++;
        if ({alu_if.op_a, alu_if.op_b, alu_if.op_code} !== {16'h0003, 16'h0003, 2'b10}) begin
            n_fail++;
            $display("FAIL esc_ops: got a=%h b=%h opc=%b required a=0003 b=0003 opc=10",
                     alu_if.op_a, alu_if.op_b, alu_if.op_code);
        end
        alu_reply(32'h0000_0009);
        while (txq.size() == 0 && t < 100) begin
            @(negedge clk); #2;
            t++;
        end
        n_checks++;
        if (txq.size() == 0) begin n_fail++; $display("FAIL esc_send_began: tx bytes 0 required >=1"); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (tx_start !== 1'b0 || dut.state !== S_OPA || alu_if.op_a !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_send: tx_start=%b state=%0d op_a=%h required 0 %0d 0000",
                     tx_start, dut.state, alu_if.op_a, S_OPA);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        txq.delete();
        alu_cnt = 0;
        send_str("1+1\015", 1);
        wait_alu("recover_start");
        alu_reply(32'h0000_0002);
        expect_tx("recover_tx", "00000002\015\012");
    endtask

    task automatic test_echo();
        alu_cnt = 0;
        send_str("1+1\015", 6);
        wait_alu("echo_start");
        alu_reply(32'h0000_0002);
        expect_tx("echo_tx", "1+1\01500000002\015\012");
    endtask

    initial begin
        alu_if.alu_done   = 1'b0;
        alu_if.alu_result = '0;
        test_reset();
`ifdef UART_CALC_ECHO_EN
        test_echo();
`else
        test_add();
        test_sub_lower();
        test_overflow();
        test_missing_operand();
        test_drop_in_wait();
        test_esc_and_reset();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
